// File: rtl/rv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_arb
// Brief    : Shares one memory bus between instruction fetch and load/store,
//            routing in-order responses back via an owner FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    // instruction fetch port
    input  logic        i_instr_req,
    input  logic [31:0] i_instr_addr,
    output logic        o_instr_ack,
    output logic        o_instr_rdy,
    output logic [31:0] o_instr_data,
    input  logic        i_instr_flush,
    // load/store port
    input  logic        i_data_req,
    input  logic [31:0] i_data_addr,
    input  logic        i_data_we,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_sel,
    output logic        o_data_ack,
    output logic        o_data_rdy,
    output logic [31:0] o_data_rdata,
    // external bus
    output logic        o_bus_req,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_we,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_sel,
    input  logic        i_bus_ack,
    input  logic        i_bus_rdy,
    input  logic [31:0] i_bus_rdata
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_STV_W-1:0] c_STV_MAX   = c_STV_W'(STARVE_MAX);
    localparam logic               c_OWN_INSTR = 1'b0;
    localparam logic               c_OWN_DATA  = 1'b1;

    // owner FIFO
    logic [DEPTH-1:0]   r_own;
    logic [DEPTH-1:0]   r_drop;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic [c_STV_W-1:0] r_starve;

    // address phase held on the bus until accepted
    logic               r_locked;
    logic               r_lock_own;
    logic               r_pend_drop;
    logic [31:0]        r_lock_addr;
    logic               r_lock_we;
    logic [31:0]        r_lock_wdata;
    logic [3:0]         r_lock_sel;

    logic               w_full;
    logic               w_grant;
    logic               w_own;
    logic               w_accept;
    logic               w_phase_drop;
    logic               w_pop;
    logic               w_head_own;
    logic               w_head_drop;
    logic [31:0]        w_addr;
    logic               w_we;
    logic [31:0]        w_wdata;
    logic [3:0]         w_sel;

    assign w_full = (r_count == c_FULL);

    always_comb begin : p_grant
        w_grant = 1'b0;
        w_own   = c_OWN_DATA;
        if (i_reset) begin
            w_grant = 1'b0;
        end else if (r_locked) begin
            w_grant = 1'b1;
            w_own   = r_lock_own;
        end else if (!w_full) begin
            // data has priority unless fetch has waited STARVE_MAX data grants
            if (i_data_req && !(i_instr_req && (r_starve == c_STV_MAX))) begin
                w_grant = 1'b1;
                w_own   = c_OWN_DATA;
            end else if (i_instr_req) begin
                w_grant = 1'b1;
                w_own   = c_OWN_INSTR;
            end
        end
    end

    always_comb begin : p_addr_mux
        w_addr  = '0;
        w_we    = 1'b0;
        w_wdata = '0;
        w_sel   = '0;
        if (w_grant) begin
            if (r_locked) begin
                w_addr  = r_lock_addr;
                w_we    = r_lock_we;
                w_wdata = r_lock_wdata;
                w_sel   = r_lock_sel;
            end else if (w_own == c_OWN_DATA) begin
                w_addr  = i_data_addr;
                w_we    = i_data_we;
                w_wdata = i_data_wdata;
                w_sel   = i_data_sel;
            end else begin
                w_addr  = i_instr_addr;
                w_sel   = 4'hF;
            end
        end
    end

    assign o_bus_req   = w_grant;
    assign o_bus_addr  = w_addr;
    assign o_bus_we    = w_we;
    assign o_bus_wdata = w_wdata;
    assign o_bus_sel   = w_sel;

    assign w_accept     = w_grant & i_bus_ack;
    // a fetch phase flushed now or earlier still completes, but silently
    assign w_phase_drop = w_grant & (w_own == c_OWN_INSTR) & (r_pend_drop | i_instr_flush);

    assign o_instr_ack = w_accept & (w_own == c_OWN_INSTR) & ~w_phase_drop;
    assign o_data_ack  = w_accept & (w_own == c_OWN_DATA);

    assign w_pop       = i_bus_rdy & (r_count != '0) & ~i_reset;
    assign w_head_own  = r_own[r_rd_ptr];
    assign w_head_drop = r_drop[r_rd_ptr] | (i_instr_flush & (w_head_own == c_OWN_INSTR));

    assign o_instr_rdy  = w_pop & (w_head_own == c_OWN_INSTR) & ~w_head_drop;
    assign o_data_rdy   = w_pop & (w_head_own == c_OWN_DATA) & ~w_head_drop;
    assign o_instr_data = o_instr_rdy ? i_bus_rdata : 32'h0;
    assign o_data_rdata = o_data_rdy  ? i_bus_rdata : 32'h0;

    always_ff @(posedge i_clk or posedge i_reset) begin : p_fifo
        if (i_reset) begin
            r_own    <= '0;
            r_drop   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_instr_flush) begin
                r_drop <= r_drop | ~r_own;
            end
            if (w_accept) begin
                r_own[r_wr_ptr]  <= w_own;
                r_drop[r_wr_ptr] <= w_phase_drop;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin : p_starve
        if (i_reset) begin
            r_starve <= '0;
        end else if (!i_instr_req || (w_accept && (w_own == c_OWN_INSTR))) begin
            r_starve <= '0;
        end else if (w_accept && (w_own == c_OWN_DATA) && (r_starve != c_STV_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin : p_lock
        if (i_reset) begin
            r_locked     <= 1'b0;
            r_lock_own   <= 1'b0;
            r_pend_drop  <= 1'b0;
            r_lock_addr  <= '0;
            r_lock_we    <= 1'b0;
            r_lock_wdata <= '0;
            r_lock_sel   <= '0;
        end else begin
            r_locked    <= w_grant & ~i_bus_ack;
            r_pend_drop <= w_phase_drop & ~i_bus_ack;
            // snapshot the phase so the requester may change its inputs meanwhile
            if (w_grant && !i_bus_ack) begin
                r_lock_own   <= w_own;
                r_lock_addr  <= w_addr;
                r_lock_we    <= w_we;
                r_lock_wdata <= w_wdata;
                r_lock_sel   <= w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_arb
// Brief    : Self-checking bench for rv_mem_arb (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_arb;

    localparam int          DEPTH      = 4;
    localparam int          STARVE_MAX = 4;
    localparam logic [31:0] IADDR      = 32'h0000_0100;
    localparam logic [31:0] DADDR      = 32'h0000_2000;
    localparam logic [31:0] WDATA      = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, instr_ack, instr_rdy, instr_flush;
    logic [31:0] instr_addr, instr_data;
    logic        data_req, data_we, data_ack, data_rdy;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_sel;
    logic        bus_req, bus_we, bus_ack, bus_rdy;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_mem_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_instr_req  (instr_req),
        .i_instr_addr (instr_addr),
        .o_instr_ack  (instr_ack),
        .o_instr_rdy  (instr_rdy),
        .o_instr_data (instr_data),
        .i_instr_flush(instr_flush),
        .i_data_req   (data_req),
        .i_data_addr  (data_addr),
        .i_data_we    (data_we),
        .i_data_wdata (data_wdata),
        .i_data_sel   (data_sel),
        .o_data_ack   (data_ack),
        .o_data_rdy   (data_rdy),
        .o_data_rdata (data_rdata),
        .o_bus_req    (bus_req),
        .o_bus_addr   (bus_addr),
        .o_bus_we     (bus_we),
        .o_bus_wdata  (bus_wdata),
        .o_bus_sel    (bus_sel),
        .i_bus_ack    (bus_ack),
        .i_bus_rdy    (bus_rdy),
        .i_bus_rdata  (bus_rdata)
    );

    typedef struct {
        logic        ir, dr, we, ack, rdy;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_we, e_iack, e_dack, e_irdy, e_drdy;
    } vec_t;

    typedef struct {
        logic        own;   // 0 = instr, 1 = data
        logic        drop;
        logic [31:0] data;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[13];

    function automatic vec_t mk(input logic ir, dr, we, ack, rdy, input logic [31:0] rdata,
                                input logic e_req, input logic [31:0] e_addr,
                                input logic e_we, e_iack, e_dack, e_irdy, e_drdy);
        vec_t v;
        v.ir = ir; v.dr = dr; v.we = we; v.ack = ack; v.rdy = rdy; v.rdata = rdata;
        v.e_req = e_req; v.e_addr = e_addr; v.e_we = e_we;
        v.e_iack = e_iack; v.e_dack = e_dack; v.e_irdy = e_irdy; v.e_drdy = e_drdy;
        return v;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: drive, check grant/ack, retire a response via the scoreboard.
    task automatic cycle(input logic ir, dr, ack, rdy, fl, e_req, e_own, e_drop);
        sb_t         e;
        logic [31:0] rd;
        instr_req   = ir;
        data_req    = dr;
        bus_ack     = ack;
        instr_flush = fl;
        rd          = $urandom;
        if (rdy && sb.size() > 0) rd = sb[0].data;
        bus_rdy   = rdy;
        bus_rdata = rd;
        if (fl) begin
            for (int k = 0; k < sb.size(); k++)
                if (sb[k].own == 1'b0) sb[k].drop = 1'b1;
        end
        #2;
        chk1("bus_req", bus_req, e_req);
        chk32("bus_addr", bus_addr, !e_req ? 32'h0 : (e_own ? DADDR : IADDR));
        chk1("instr_ack", instr_ack, e_req & ack & ~e_own & ~e_drop);
        chk1("data_ack", data_ack, e_req & ack & e_own);
        if (rdy && sb.size() > 0) begin
            e = sb.pop_front();
            chk1("instr_rdy", instr_rdy, ~e.own & ~e.drop);
            chk1("data_rdy", data_rdy, e.own);
            if (!e.own && !e.drop) chk32("instr_data", instr_data, rd);
            if (e.own) chk32("data_rdata", data_rdata, rd);
        end else begin
            chk1("instr_rdy_idle", instr_rdy, 1'b0);
            chk1("data_rdy_idle", data_rdy, 1'b0);
        end
        if (e_req && ack) begin
            e.own  = e_own;
            e.drop = e_drop;
            e.data = $urandom;
            sb.push_back(e);
        end
        tick();
        instr_flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic own_seq[10];

        // ir dr we ack rdy rdata      | req addr  we iack dack irdy drdy
        tbl[0]  = mk(0, 0, 0, 0, 1, 32'h0BAD, 0, 32'h0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 1, 0, 32'h0,    1, IADDR, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 32'h0,    0, 32'h0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 1, 32'h13,   0, 32'h0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 32'h0,    1, DADDR, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 1, 32'hCAFE, 0, 32'h0, 0, 0, 0, 0, 1);
        tbl[6]  = mk(1, 1, 0, 1, 0, 32'h0,    1, DADDR, 0, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 1, 1, 32'h55,   1, IADDR, 0, 1, 0, 0, 1);
        tbl[8]  = mk(1, 0, 0, 0, 1, 32'h77,   1, IADDR, 0, 0, 0, 1, 0);
        tbl[9]  = mk(1, 1, 1, 1, 0, 32'h0,    1, IADDR, 0, 1, 0, 0, 0);
        tbl[10] = mk(0, 1, 1, 1, 0, 32'h0,    1, DADDR, 1, 0, 1, 0, 0);
        tbl[11] = mk(0, 0, 0, 0, 1, 32'h99,   0, 32'h0, 0, 0, 0, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 1, 32'h11,   0, 32'h0, 0, 0, 0, 0, 1);

        instr_addr = IADDR; data_addr = DADDR; data_wdata = WDATA; data_sel = 4'h3;
        data_we = 1'b0; bus_ack = 1'b0; bus_rdy = 1'b0; bus_rdata = 32'h0;
        instr_flush = 1'b0;
        // requests held high during reset must not reach the bus
        instr_req = 1'b1; data_req = 1'b1; rst = 1'b1;
        #2;
        chk1("reset_bus_req", bus_req, 1'b0);
        chk32("reset_bus_addr", bus_addr, 32'h0);
        chk1("reset_instr_ack", instr_ack, 1'b0);
        chk1("reset_data_ack", data_ack, 1'b0);
        chk1("reset_instr_rdy", instr_rdy, 1'b0);
        chk1("reset_data_rdy", data_rdy, 1'b0);
        instr_req = 1'b0; data_req = 1'b0;
        tick();
        rst = 1'b0;

        // vector table
        for (int i = 0; i < 13; i++) begin
            instr_req = tbl[i].ir;  data_req = tbl[i].dr; data_we = tbl[i].we;
            bus_ack = tbl[i].ack;   bus_rdy = tbl[i].rdy; bus_rdata = tbl[i].rdata;
            #2;
            chk1($sformatf("v%0d_bus_req", i), bus_req, tbl[i].e_req);
            chk32($sformatf("v%0d_bus_addr", i), bus_addr, tbl[i].e_addr);
            chk1($sformatf("v%0d_bus_we", i), bus_we, tbl[i].e_we);
            chk1($sformatf("v%0d_instr_ack", i), instr_ack, tbl[i].e_iack);
            chk1($sformatf("v%0d_data_ack", i), data_ack, tbl[i].e_dack);
            chk1($sformatf("v%0d_instr_rdy", i), instr_rdy, tbl[i].e_irdy);
            chk1($sformatf("v%0d_data_rdy", i), data_rdy, tbl[i].e_drdy);
            if (tbl[i].e_irdy) chk32($sformatf("v%0d_instr_data", i), instr_data, tbl[i].rdata);
            if (tbl[i].e_drdy) chk32($sformatf("v%0d_data_rdata", i), data_rdata, tbl[i].rdata);
            if (tbl[i].e_req && tbl[i].e_addr == DADDR) begin
                chk32($sformatf("v%0d_bus_wdata", i), bus_wdata, WDATA);
                chk32($sformatf("v%0d_bus_sel", i), 32'(bus_sel), 32'h3);
            end
            tick();
        end
        instr_req = 1'b0; data_req = 1'b0; data_we = 1'b0; bus_ack = 1'b0; bus_rdy = 1'b0;

        // starvation: both requesters always active
        own_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++)
            cycle(1, 1, 1, (sb.size() > 0), 0, 1, own_seq[i], 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);

        // full FIFO blocks grants, including in the cycle of a pop
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, 1, 0, 0, 1, 1, 0);
        cycle(1, 1, 1, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0);

        // flush with {I, D, I} outstanding; first response arrives in the flush cycle
        cycle(1, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 1, 1, 0, 0, 1, 1, 0);
        cycle(1, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);

        // flush during a locked, unacked fetch phase; fetch moves on meanwhile
        cycle(1, 0, 0, 0, 0, 1, 0, 0);
        instr_addr = 32'h0000_0500;
        cycle(0, 0, 0, 0, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 0, 1, 0, 1);
        cycle(0, 0, 1, 0, 0, 1, 0, 1);
        instr_addr = IADDR;
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(1, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);

        // asynchronous reset with two outstanding
        cycle(0, 1, 1, 0, 0, 1, 1, 0);
        cycle(0, 1, 1, 0, 0, 1, 1, 0);
        instr_req = 1'b1; data_req = 1'b1; bus_ack = 1'b1; bus_rdy = 1'b1; bus_rdata = 32'h1234_5678;
        #2;
        rst = 1'b1;
        #1;
        chk1("async_bus_req", bus_req, 1'b0);
        chk32("async_bus_addr", bus_addr, 32'h0);
        chk1("async_instr_ack", instr_ack, 1'b0);
        chk1("async_data_ack", data_ack, 1'b0);
        chk1("async_instr_rdy", instr_rdy, 1'b0);
        chk1("async_data_rdy", data_rdy, 1'b0);
        chk32("async_data_rdata", data_rdata, 32'h0);
        chk32("async_count", 32'(dut.r_count), 32'h0);
        tick();
        instr_req = 1'b0; data_req = 1'b0; bus_ack = 1'b0; bus_rdy = 1'b0;
        rst = 1'b0;
        sb.delete();
        cycle(0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 1, 1, 0);
        cycle(0, 0, 0, 1, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
